// File: rtl/spi_master_mc.sv
// ============================================================================
// Module   : spi_master_mc
// Brief    : Full-duplex SPI master, all CPOL/CPHA modes, MSB/LSB first,
//            one-hot active-low chip select out of NUM_CS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CS     = 4,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SCLK_FREQ  = 5_000_000,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy,
    output logic                  finish,
    output logic                  mosi,
    output logic                  sclk,
    output logic [NUM_CS-1:0]     ss_n
);

    localparam int HALF = CLK_FREQ / (2 * SCLK_FREQ);
    localparam int CW   = (HALF > 2) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [10:0]   LAST_EDGE = 11'(2 * DATA_WIDTH);

    generate
        if (HALF < 2) begin : g_half_check
            $error("spi_master_mc: CLK_FREQ/(2*SCLK_FREQ) must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_XFER   = 3'd2,
        S_TRAIL  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [10:0]           edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic [CS_W-1:0]       sel_q, sel_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_CS-1:0]     ss_n_q, ss_n_d;
    logic                  busy_q, busy_d;
    logic                  finish_q, finish_d;

    logic [DATA_WIDTH-1:0] w_tx_shift;
    logic [10:0]           w_edge_nxt;
    logic                  w_active;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_d     = data_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sel_d      = sel_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        w_tx_shift = lsb_q ? {1'b0, tx_q[DATA_WIDTH-1:1]} : {tx_q[DATA_WIDTH-2:0], 1'b0};
        w_edge_nxt = edge_q + 11'd1;

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                cnt_d  = '0;
                edge_d = '0;
                if (start) begin
                    state_d = S_LEAD;
                    tx_d    = data_i;
                    rx_d    = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    sel_d   = cs_sel;
                    // CPHA=0 slaves sample on the first edge, so the first bit must already be out.
                    mosi_d  = cpha ? 1'b0 : (lsb_first ? data_i[0] : data_i[DATA_WIDTH-1]);
                end
            end
            S_LEAD: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d  = '0;
                    edge_d = w_edge_nxt;
                    sclk_d = ~sclk_q;
                    // Odd edges are leading; the sampling edge is the one not used for shifting.
                    if (w_edge_nxt[0] != cpha_q) begin
                        rx_d = lsb_q ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};
                    end else if (cpha_q && (w_edge_nxt == 11'd1)) begin
                        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
                    end else if (w_edge_nxt != LAST_EDGE) begin
                        tx_d   = w_tx_shift;
                        mosi_d = lsb_q ? w_tx_shift[0] : w_tx_shift[DATA_WIDTH-1];
                    end
                    if (w_edge_nxt == LAST_EDGE) begin
                        state_d = S_TRAIL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TRAIL: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                    data_d  = rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                sclk_d  = cpol;
                mosi_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        w_active = (state_d == S_LEAD) || (state_d == S_XFER) || (state_d == S_TRAIL);
        ss_n_d   = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (w_active && (int'(sel_d) == i)) begin
                ss_n_d[i] = 1'b0;
            end
        end
        busy_d   = (state_d != S_IDLE);
        finish_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            data_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            sel_q    <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_n_q   <= '1;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            data_q   <= data_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
            sel_q    <= sel_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ss_n_q   <= ss_n_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign data_o = data_q;
    assign busy   = busy_q;
    assign finish = finish_q;
    assign mosi   = mosi_q;
    assign sclk   = sclk_q;
    assign ss_n   = ss_n_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_mc.sv
// ============================================================================
// Module   : tb_spi_master_mc
// Brief    : Directed self-checking bench for spi_master_mc with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_mc;

    localparam int DW      = 8;
    localparam int NCS     = 4;
    localparam int CLKF    = 50_000_000;
    localparam int SCLKF   = 5_000_000;
    localparam int HALF    = CLKF / (2 * SCLKF);
    localparam int EXP_LAT = (2 * DW + 2) * HALF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          lsb_first = 1'b0;
    logic [1:0]    cs_sel = 2'd0;
    logic [DW-1:0] data_i = '0;
    logic          loop_en = 1'b1;
    logic          miso_val = 1'b0;
    logic          miso;
    logic [DW-1:0] data_o;
    logic          busy, finish, mosi, sclk;
    logic [NCS-1:0] ss_n;

    logic          start2 = 1'b0;
    logic [2:0]    cs_sel2 = 3'd0;
    logic [DW-1:0] data_o2;
    logic          busy2, finish2, mosi2, sclk2;
    logic [4:0]    ss_n2;

    assign miso = loop_en ? mosi : miso_val;

    always #5 clk = ~clk;

    spi_master_mc #(.DATA_WIDTH(DW), .NUM_CS(NCS), .CLK_FREQ(CLKF), .SCLK_FREQ(SCLKF)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(cs_sel), .data_i(data_i), .miso(miso),
        .data_o(data_o), .busy(busy), .finish(finish), .mosi(mosi), .sclk(sclk), .ss_n(ss_n)
    );

    spi_master_mc #(.DATA_WIDTH(DW), .NUM_CS(5), .CLK_FREQ(CLKF), .SCLK_FREQ(SCLKF)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_sel(cs_sel2), .data_i(data_i), .miso(mosi2),
        .data_o(data_o2), .busy(busy2), .finish(finish2), .mosi(mosi2), .sclk(sclk2), .ss_n(ss_n2)
    );

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] bits;
    } item_t;

    item_t sb[$];

    int checks = 0;
    int errors = 0;

    // Slave-side monitor: counts sclk edges, captures mosi on the slave's sampling edge, polices ss_n.
    int            edge_cnt = 0;
    int            ss_bad = 0;
    int            ss2_bad = 0;
    int            snap_edges = 0;
    int            snap_ss = 0;
    logic [DW-1:0] mon_bits = '0;
    logic          sclk_prev = 1'b0;
    logic          mon_cpol = 1'b0;
    logic          mon_cpha = 1'b0;
    logic [NCS-1:0] exp_ss = '1;
    bit            mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sclk !== sclk_prev) begin
                edge_cnt++;
                if (busy && ((mon_cpha == 1'b0) ? (sclk != mon_cpol) : (sclk == mon_cpol)))
                    mon_bits = {mon_bits[DW-2:0], mosi};
            end
            sclk_prev = sclk;
            if (busy && !finish) begin
                if (ss_n !== exp_ss) ss_bad++;
            end else if (ss_n !== 4'hF) begin
                ss_bad++;
            end
            if (ss_n2 !== 5'h1F) ss2_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
        return r;
    endfunction

    task automatic launch(input logic cp, input logic ch, input logic lsb, input logic [1:0] sel,
                          input logic [DW-1:0] d, input logic lp, input logic mv, input bit hold);
        item_t it;
        @(negedge clk);
        cpol = cp; cpha = ch; lsb_first = lsb; cs_sel = sel; data_i = d;
        loop_en = lp; miso_val = mv;
        mon_cpol = cp; mon_cpha = ch;
        exp_ss = 4'hF & ~(4'b0001 << sel);
        it.rx   = lp ? d : {DW{mv}};
        it.bits = lsb ? rev(d) : d;
        sb.push_back(it);
        @(negedge clk);
        chk("sclk_idle", 32'(sclk), 32'(cp));
        start = 1'b1;
        @(posedge clk);
        #1;
        snap_edges = edge_cnt;
        snap_ss    = ss_bad;
        if (!hold) start = 1'b0;
    endtask

    // n0 = negedges already consumed since the accepting clock edge.
    task automatic wait_done(input int n0);
        int    n;
        bit    got;
        item_t it;
        n = n0;
        got = 1'b0;
        while (n < n0 + 400 && !got) begin
            @(negedge clk);
            #1;
            n++;
            if (finish === 1'b1) got = 1'b1;
        end
        if (!got) begin
            chk("done_timeout", 32'(finish), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        it = sb.pop_front();
        chk("latency", 32'(n - 1), 32'(EXP_LAT));
        chk("sclk_edges", 32'(edge_cnt - snap_edges), 32'(2 * DW));
        chk("mosi_bits", 32'(mon_bits), 32'(it.bits));
        chk("ss_during", 32'(ss_bad - snap_ss), 32'd0);
        @(negedge clk);
        #1;
        chk("finish_width", 32'(finish), 32'd0);
        chk("data_o", 32'(data_o), 32'(it.rx));
    endtask

    initial begin
        int w;
        int bc;
        bit got2;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        sclk_prev = sclk;
        mon_en = 1'b1;
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_ss_n", 32'(ss_n), 32'hF);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        rst_n = 1'b1;

        // Mode 0, MSB first, loopback, cs 2
        launch(1'b0, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b1, 1'b0, 1'b0);
        wait_done(0);

        // Mode 3, LSB first, miso tied high, cs 0
        launch(1'b1, 1'b1, 1'b1, 2'd0, 8'h3C, 1'b0, 1'b1, 1'b0);
        wait_done(0);

        // Out-of-range select on a 5-slave instance: no chip select may ever drop
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; data_i = 8'h6B;
        cs_sel2 = 3'd5; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        got2 = 1'b0;
        w = 0;
        while (w < 400 && !got2) begin
            @(negedge clk);
            #1;
            w++;
            if (finish2 === 1'b1) got2 = 1'b1;
        end
        chk("oor_done", 32'(finish2), 32'd1);
        @(negedge clk);
        #1;
        chk("oor_data_o", 32'(data_o2), 32'h6B);
        chk("oor_ss_n", 32'(ss2_bad), 32'd0);

        // start pulsed mid-XFER with new data and modes must be ignored
        launch(1'b0, 1'b1, 1'b0, 2'd1, 8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        data_i = 8'hFF; cpol = 1'b1; cs_sel = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(31);
        bc = 0;
        repeat (150) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("no_second_xfer", 32'(bc), 32'd0);

        // Reset after the 7th sclk edge discards the partial word
        launch(1'b0, 1'b0, 1'b0, 2'd1, 8'hC3, 1'b1, 1'b0, 1'b0);
        w = 0;
        while ((edge_cnt - snap_edges) < 7 && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("edge7_reached", 32'(edge_cnt - snap_edges), 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_sclk", 32'(sclk), 32'd0);
        chk("mid_rst_ss_n", 32'(ss_n), 32'hF);
        chk("mid_rst_mosi", 32'(mosi), 32'd0);
        chk("mid_rst_data_o", 32'(data_o), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_finish", 32'(finish), 32'd0);
        rst_n = 1'b1;
        sb.delete();
        launch(1'b0, 1'b0, 1'b1, 2'd3, 8'h96, 1'b1, 1'b0, 1'b0);
        wait_done(0);

        // Back-to-back with start held: exactly one IDLE cycle between transfers
        launch(1'b1, 1'b0, 1'b0, 2'd2, 8'h11, 1'b1, 1'b0, 1'b1);
        data_i = 8'h22;
        begin
            item_t it2;
            it2.rx = 8'h22;
            it2.bits = 8'h22;
            sb.push_back(it2);
        end
        wait_done(0);
        chk("b2b_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("b2b_restart", 32'(busy), 32'd1);
        snap_edges = edge_cnt;
        snap_ss = ss_bad;
        start = 1'b0;
        wait_done(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
